// File: rtl/regfile_pkg.sv
// Shared constants, types and the write-port arbitration helper for regfile_mp.
package regfile_pkg;

  localparam int unsigned N_DEF  = 32;
  localparam int unsigned R_DEF  = 5;
  localparam int unsigned NR_DEF = 2;
  localparam int unsigned NW_DEF = 1;

  // Widest address and write-port count the arbitration helper handles.
  localparam int unsigned R_MAX  = 16;
  localparam int unsigned NW_MAX = 2;

  typedef logic [N_DEF-1:0] word_t;
  typedef logic [R_DEF-1:0] addr_t;

  // Result of write-port arbitration for one address.
  typedef struct packed {
    logic hit;   // some enabled write port targets the address
    logic port;  // highest-index matching port
  } wsel_t;

  // Returns the highest-index enabled write port whose address matches a.
  // Addresses are zero-extended to R_MAX bits and packed at an R_MAX stride.
  function automatic wsel_t win_port(input logic [NW_MAX-1:0]       en,
                                     input logic [NW_MAX*R_MAX-1:0] addrs,
                                     input logic [R_MAX-1:0]        a);
    wsel_t s;
    s = '0;
    for (int j = 0; j < int'(NW_MAX); j++) begin
      if (en[j] && (addrs[j*R_MAX +: R_MAX] == a)) begin
        s.hit  = 1'b1;
        s.port = 1'(j);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: reserve sets, writes clear (reserve wins on a tie),
// busy_cnt tracked incrementally as the population of busy bits.
// Ports: clk, rst (async active-low), we/wr_addr (already-filtered write
// enables and addresses), rsv_en/rsv_addr (already-filtered reserve),
// busy (registered busy bits), busy_cnt (registered population).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned R  = R_DEF,
  parameter int unsigned NW = NW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NW-1:0]     we,
  input  logic [NW*R-1:0]   wr_addr,
  input  logic              rsv_en,
  input  logic [R-1:0]      rsv_addr,
  output logic [(1<<R)-1:0] busy,
  output logic [R:0]        busy_cnt
);

  localparam int unsigned D = 1 << R;

  logic [D-1:0] clr;
  logic [D-1:0] set;
  logic [D-1:0] busy_nxt;
  logic [R:0]   cnt_nxt;
  logic         inc;
  logic [1:0]   dec;

  // Per-register clear and set masks for this cycle.
  always_comb begin
    clr = '0;
    set = '0;
    for (int i = 0; i < int'(D); i++) begin
      for (int j = 0; j < int'(NW); j++) begin
        if (we[j] && (wr_addr[j*R +: R] == R'(i))) clr[i] = 1'b1;
      end
      if (rsv_en && (rsv_addr == R'(i))) set[i] = 1'b1;
    end
  end

  // Next busy bits and counter delta; a reserve overrides a same-address clear.
  always_comb begin
    busy_nxt = busy;
    inc      = 1'b0;
    dec      = 2'd0;
    for (int i = 0; i < int'(D); i++) begin
      if (set[i]) begin
        busy_nxt[i] = 1'b1;
        if (!busy[i]) inc = 1'b1;
      end else if (clr[i]) begin
        busy_nxt[i] = 1'b0;
        if (busy[i]) dec = dec + 2'd1;
      end
    end
    cnt_nxt = busy_cnt + (R+1)'(inc) - (R+1)'(dec);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write-to-read bypass and a
// busy-bit scoreboard for pending-write detection.
// Ports: clk, rst (async active-low), rd_addr/rd_data/rd_busy (NR read ports,
// combinational and bypassed), wr_en/wr_addr/wr_data (NW write ports, higher
// index wins), rsv_en/rsv_addr (destination reservation), busy_cnt.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned R        = R_DEF,
  parameter int unsigned NR       = NR_DEF,
  parameter int unsigned NW       = NW_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NR*R-1:0] rd_addr,
  output logic [NR*N-1:0] rd_data,
  output logic [NR-1:0]   rd_busy,
  input  logic [NW-1:0]   wr_en,
  input  logic [NW*R-1:0] wr_addr,
  input  logic [NW*N-1:0] wr_data,
  input  logic            rsv_en,
  input  logic [R-1:0]    rsv_addr,
  output logic [R:0]      busy_cnt
);

  localparam int unsigned D = 1 << R;

  logic [N-1:0]            mem [D];
  logic [D-1:0]            busy;
  logic [NW-1:0]           we_eff;
  logic                    rsv_eff;
  logic [NW_MAX*R_MAX-1:0] wr_addr_pad;
  logic [NW_MAX*N-1:0]     wr_data_pad;

  // Drop writes and reservations to register 0 when it is hardwired.
  always_comb begin
    we_eff = wr_en;
    for (int j = 0; j < int'(NW); j++) begin
      if ((ZERO_REG != 0) && (wr_addr[j*R +: R] == '0)) we_eff[j] = 1'b0;
    end
    rsv_eff = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
  end

  // Widen the write-port bundle to the fixed shape the arbitration helper takes.
  always_comb begin
    wr_addr_pad = '0;
    for (int j = 0; j < int'(NW); j++) begin
      wr_addr_pad[j*R_MAX +: R_MAX] = R_MAX'(wr_addr[j*R +: R]);
    end
    wr_data_pad = (NW_MAX*N)'(wr_data);
  end

  // Data array; later ports overwrite earlier ones on an address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(D); i++) mem[i] <= '0;
    end else begin
      for (int j = 0; j < int'(NW); j++) begin
        if (we_eff[j]) mem[wr_addr[j*R +: R]] <= wr_data[j*N +: N];
      end
    end
  end

  regfile_scoreboard #(
    .R  (R),
    .NW (NW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we       (we_eff),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_eff),
    .rsv_addr (rsv_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // Read ports: zero register, then write bypass, then stored word.
  for (genvar k = 0; k < int'(NR); k++) begin : g_rd
    logic [R-1:0] a;
    logic         is_zero;
    wsel_t        ws;
    logic [N-1:0] d;
    logic         b;

    assign a       = rd_addr[k*R +: R];
    assign is_zero = (ZERO_REG != 0) && (a == '0);

    always_comb begin
      ws = win_port(NW_MAX'(we_eff), wr_addr_pad, R_MAX'(a));
      if (is_zero) begin
        d = '0;
      end else if (ws.hit) begin
        d = ws.port ? wr_data_pad[N +: N] : wr_data_pad[0 +: N];
      end else begin
        d = mem[a];
      end
      // A write landing this cycle retires the pending producer.
      b = busy[a] && !ws.hit && !is_zero;
    end

    assign rd_data[k*N +: N] = d;
    assign rd_busy[k]        = b;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (N=32, R=5, NR=2, NW=2).
module tb_regfile_mp;

  localparam int unsigned N  = 32;
  localparam int unsigned R  = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;

  logic            clk;
  logic            rst;
  logic [NR*R-1:0] rd_addr;
  logic [NR*N-1:0] rd_data;
  logic [NR-1:0]   rd_busy;
  logic [NW-1:0]   wr_en;
  logic [NW*R-1:0] wr_addr;
  logic [NW*N-1:0] wr_data;
  logic            rsv_en;
  logic [R-1:0]    rsv_addr;
  logic [R:0]      busy_cnt;

  int total = 0;
  int bad   = 0;

  regfile_mp #(
    .N        (N),
    .R        (R),
    .NR       (NR),
    .NW       (NW),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive helpers (no checking inside).
  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic set_rd(input logic [R-1:0] a0, input logic [R-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    set_rd(5'd0, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (busy_cnt !== 6'd0) begin
      bad++;
      $display("FAIL reset_cnt: got %0d want 0", busy_cnt);
    end
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      #1;
      total++;
      if (rd_data !== 64'd0) begin
        bad++;
        $display("FAIL reset_data a=%0d: got %h want 0", a, rd_data);
      end
      total++;
      if (rd_busy !== 2'b00) begin
        bad++;
        $display("FAIL reset_busy a=%0d: got %b want 00", a, rd_busy);
      end
    end
  endtask

  task automatic test_write_bypass();
    @(negedge clk);
    idle();
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd5};
    wr_data = {32'h0, 32'hDEADBEEF};
    set_rd(5'd5, 5'd5);
    #1;
    total++;
    if (rd_data !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL bypass_r5: got %h want deadbeefdeadbeef", rd_data);
    end
    @(posedge clk);
    #1;
    idle();
    #1;
    total++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL stored_r5: got %h want deadbeef", rd_data[31:0]);
    end
    @(negedge clk);
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd0};
    wr_data = {32'h0, 32'h1234};
    set_rd(5'd0, 5'd5);
    #1;
    total++;
    if (rd_data !== {32'hDEADBEEF, 32'h0}) begin
      bad++;
      $display("FAIL r0_bypass: got %h want deadbeef00000000", rd_data);
    end
    @(posedge clk);
    #1;
    idle();
    #1;
    total++;
    if (rd_data[31:0] !== 32'h0) begin
      bad++;
      $display("FAIL r0_stored: got %h want 0", rd_data[31:0]);
    end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    idle();
    wr_en   = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {32'h5555, 32'hAAAA};
    set_rd(5'd7, 5'd7);
    #1;
    total++;
    if (rd_data !== {32'h5555, 32'h5555}) begin
      bad++;
      $display("FAIL dual_bypass: got %h want 0000555500005555", rd_data);
    end
    @(posedge clk);
    #1;
    idle();
    #1;
    total++;
    if (rd_data !== {32'h5555, 32'h5555}) begin
      bad++;
      $display("FAIL dual_stored: got %h want 0000555500005555", rd_data);
    end
  endtask

  task automatic test_reserve();
    logic [R:0] exp_cnt [3];
    logic [R-1:0] ra [3];
    exp_cnt = '{6'd1, 6'd1, 6'd2};
    ra      = '{5'd3, 5'd3, 5'd4};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      rsv_en   = 1'b1;
      rsv_addr = ra[i];
      set_rd(5'd3, 5'd4);
      @(posedge clk);
      #1;
      total++;
      if (busy_cnt !== exp_cnt[i]) begin
        bad++;
        $display("FAIL rsv_cnt step=%0d: got %0d want %0d", i, busy_cnt, exp_cnt[i]);
      end
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (rd_busy !== 2'b11) begin
      bad++;
      $display("FAIL rsv_busy: got %b want 11", rd_busy);
    end
    // Write r3 while reserving r3: new producer keeps it busy.
    wr_en    = 2'b01;
    wr_addr  = {5'd0, 5'd3};
    wr_data  = {32'h0, 32'h33};
    rsv_en   = 1'b1;
    rsv_addr = 5'd3;
    #1;
    total++;
    if (rd_busy !== 2'b10) begin
      bad++;
      $display("FAIL wr_rsv_comb_busy: got %b want 10", rd_busy);
    end
    @(posedge clk);
    #1;
    idle();
    #1;
    total++;
    if (busy_cnt !== 6'd2) begin
      bad++;
      $display("FAIL wr_rsv_cnt: got %0d want 2", busy_cnt);
    end
    total++;
    if (rd_busy !== 2'b11) begin
      bad++;
      $display("FAIL wr_rsv_busy: got %b want 11", rd_busy);
    end
    // Write r4: busy drops combinationally, count follows at the edge.
    @(negedge clk);
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd4};
    wr_data = {32'h0, 32'h44};
    #1;
    total++;
    if (rd_busy !== 2'b01) begin
      bad++;
      $display("FAIL wr_r4_comb_busy: got %b want 01", rd_busy);
    end
    @(posedge clk);
    #1;
    idle();
    #1;
    total++;
    if (busy_cnt !== 6'd1) begin
      bad++;
      $display("FAIL wr_r4_cnt: got %0d want 1", busy_cnt);
    end
    total++;
    if (rd_busy !== 2'b01) begin
      bad++;
      $display("FAIL wr_r4_busy: got %b want 01", rd_busy);
    end
  endtask

  task automatic test_dual_busy();
    // r3 is still busy from the previous scenario.
    @(negedge clk);
    idle();
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    @(posedge clk);
    #1;
    total++;
    if (busy_cnt !== 6'd2) begin
      bad++;
      $display("FAIL rsv_r9_cnt: got %0d want 2", busy_cnt);
    end
    @(negedge clk);
    idle();
    wr_en   = 2'b11;
    wr_addr = {5'd9, 5'd9};
    wr_data = {32'h99, 32'h90};
    set_rd(5'd9, 5'd3);
    #1;
    total++;
    if (rd_busy !== 2'b10) begin
      bad++;
      $display("FAIL dual_clr_comb_busy: got %b want 10", rd_busy);
    end
    @(posedge clk);
    #1;
    total++;
    if (busy_cnt !== 6'd1) begin
      bad++;
      $display("FAIL dual_clr_cnt: got %0d want 1", busy_cnt);
    end
    @(negedge clk);
    idle();
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd10};
    wr_data = {32'h0, 32'hA0};
    @(posedge clk);
    #1;
    total++;
    if (busy_cnt !== 6'd1) begin
      bad++;
      $display("FAIL clr_clear_cnt: got %0d want 1", busy_cnt);
    end
    // Reserving r0 is dropped.
    @(negedge clk);
    idle();
    rsv_en   = 1'b1;
    rsv_addr = 5'd0;
    set_rd(5'd0, 5'd3);
    @(posedge clk);
    #1;
    total++;
    if (busy_cnt !== 6'd1) begin
      bad++;
      $display("FAIL rsv_r0_cnt: got %0d want 1", busy_cnt);
    end
    total++;
    if (rd_busy !== 2'b10) begin
      bad++;
      $display("FAIL rsv_r0_busy: got %b want 10", rd_busy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    idle();
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd1};
    wr_data = {32'h0, 32'h77};
    @(negedge clk);
    idle();
    rsv_en   = 1'b1;
    rsv_addr = 5'd2;
    @(negedge clk);
    idle();
    set_rd(5'd1, 5'd2);
    #1;
    total++;
    if (rd_data[31:0] !== 32'h77 || busy_cnt !== 6'd2 || rd_busy !== 2'b10) begin
      bad++;
      $display("FAIL pre_rst: data=%h cnt=%0d busy=%b want 77/2/10",
               rd_data[31:0], busy_cnt, rd_busy);
    end
    rst = 1'b0;
    #1;
    total++;
    if (rd_data !== 64'd0 || busy_cnt !== 6'd0 || rd_busy !== 2'b00) begin
      bad++;
      $display("FAIL in_rst: data=%h cnt=%0d busy=%b want 0/0/00",
               rd_data, busy_cnt, rd_busy);
    end
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (rd_data !== 64'd0 || busy_cnt !== 6'd0 || rd_busy !== 2'b00) begin
      bad++;
      $display("FAIL post_rst: data=%h cnt=%0d busy=%b want 0/0/00",
               rd_data, busy_cnt, rd_busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_dual_write();
    test_reserve();
    test_dual_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: the successor to the single-write, two-read register file used by the datapath. It adds a configurable number of read and write ports, same-cycle write-to-read bypass and a busy-bit scoreboard so the issue stage can detect pending writes without a separate hazard unit. It sits between decode/issue and writeback and keeps the hardwired-zero register-0 convention.

## Interface
- `N`, default 32: data width.
- `R`, default 5: address width; depth is 2**R.
- `NR`, default 2: read ports, 1..4.
- `NW`, default 1: write ports, 1..2.
- `ZERO_REG`, default 1: 1 means register 0 reads 0 and ignores writes and reservations.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rd_addr` in NR*R: read addresses; port k occupies bits [k*R +: R].
- `rd_data` out NR*N: read data, combinational, bypassed.
- `rd_busy` out NR: addressed register has a pending write (bypassed).
- `wr_en` in NW: per-port write enables.
- `wr_addr` in NW*R: write addresses.
- `wr_data` in NW*N: write data.
- `rsv_en` in 1: reserve a destination, which sets its busy bit.
- `rsv_addr` in R: register to reserve.
- `busy_cnt` out R+1: number of registers currently busy.

## Operation
- Storage: 2**R words of N bits, plus 2**R busy bits.
- Write: on the rising edge, word[`wr_addr[j]`] <= `wr_data[j]` when `wr_en[j]` is high.
  - Both ports writing the same address: port 1 wins.
  - The busy bit of every written address clears.
- Reserve: on the rising edge, busy[`rsv_addr`] <= 1 when `rsv_en` is high.
  - Reserve and write to the same address in the same cycle: reserve wins and busy stays 1 (a new producer has issued).
- Read port k returns data in this priority order:
  - 0 if `ZERO_REG` and the address is 0;
  - else `wr_data` of the highest-index enabled write port whose address matches (bypass);
  - else the stored word.
- `rd_busy[k]` = busy[addr] AND NOT (some enabled write matches addr this cycle).
  - Forced to 0 for address 0 when `ZERO_REG`.
  - `rsv_en` does not bypass into `rd_busy`.
- `busy_cnt` tracks the population of busy bits as an up/down counter, not by recount. Next value = current + (reserve sets a clear bit) − (number of distinct set bits cleared by writes without a same-address reserve).
  - Writes to an already-clear bit do not decrement.
  - Reserving an already-busy bit does not increment.
  - Two ports writing the same busy address decrement once.
- `ZERO_REG` = 1: writes and reservations to address 0 are dropped entirely.

## Timing
- Reset (`rst` low, asynchronous):
  - all words 0, all busy bits 0, `busy_cnt` = 0;
  - hence all `rd_data` = 0 and all `rd_busy` = 0 while in reset.
- Reset asserted mid-cycle overrides any write or reserve in flight; nothing is retained.
- Read latency is zero: a combinational path from `rd_addr`, `wr_*` and the stored state.
- Write-to-array latency is 1 edge; bypass makes the written value visible in the same cycle.
- Busy set latency is 1 edge; busy clear is visible combinationally via bypass, then registered at the edge.
- `busy_cnt` is registered and reflects the state after the last edge.
- `busy_cnt` cannot exceed 2**R (or 2**R − 1 when `ZERO_REG`), so no saturation logic is required.

## Structure
- `regfile_pkg` holds:
  - default `N`/`R`/`NR`/`NW` constants;
  - `typedef logic [N-1:0] word_t` and `typedef logic [R-1:0] addr_t`;
  - a function returning the winning write port for a given address.
- One sub-module, `regfile_scoreboard`: busy bits, reserve/clear priority and `busy_cnt`.
- The data array and bypass muxes live in `regfile_mp`.

## Test plan
- Reset, then read all addresses on every port: `rd_data` = 0, `rd_busy` = 0, `busy_cnt` = 0.
- Write 0xDEADBEEF to r5 and read r5 in the same cycle: `rd_data` = 0xDEADBEEF combinationally and still 0xDEADBEEF after the edge. Write 0x1234 to r0: reads 0.
- `NW` = 2, port 0 writes 0xAAAA to r7 and port 1 writes 0x5555 to r7 in the same cycle: read r7 = 0x5555, both before and after the edge.
- Reserve r3 (`busy_cnt` → 1), reserve r3 again (stays 1), reserve r4 (→ 2). Then write r3 while reserving r3: busy stays, count 2. Write r4: `rd_busy` for r4 drops in the same cycle and the count → 1.
- `NW` = 2: both ports write busy r9 in the same cycle: `busy_cnt` decrements by exactly 1. Writing clear r10: count unchanged.
- Load r1 = 0x77, reserve r2, then pulse `rst` low between edges: `rd_data` and `busy_cnt` go to 0 immediately and stay 0 after release until new writes.
